fp_add_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined single-precision floating-point adder among N requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the adder. It tracks the issuing requester's ID through the adder's fixed latency and routes each result back to that requester as a one-cycle response pulse. It sits between the client blocks and the adder/special-case datapath, and never inspects operand values.

---
 rtl/fp_add_arbiter_pkg.sv | 26 ++
 rtl/fp_add_arbiter_if.sv | 45 ++++
 rtl/fp_add_arbiter_rr_arbiter.sv | 40 ++++
 rtl/fp_add_arbiter.sv | 139 +++++++++++++
 tb/tb_fp_add_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_add_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared constants and types for the shared FP adder arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

  // Single-precision word width
  localparam int FP_W = 32;

  // Canonical quiet NaN and positive infinity encodings
  localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F80_0000;

  // Tag id field is sized for the largest supported requester count (8)
  localparam int TAG_IDW = 3;

  // One entry of the tag pipeline that shadows the adder
  typedef struct packed {
    logic               v;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/fp_add_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_arbiter_if
//  Description : Requester, adder and response bundle of the shared FP adder
//                arbiter. The slave modport is the arbiter's view.
//  Revision    : 1.0  initial release
// ============================================================================
interface fp_add_arbiter_if
  import fp_pkg::*;
#(
  parameter int N = 4
);

  // Requester side
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [FP_W*N-1:0] req_a;
  logic [FP_W*N-1:0] req_b;

  // Adder side
  logic              add_valid;
  logic [FP_W-1:0]   add_a;
  logic [FP_W-1:0]   add_b;
  logic              add_result_valid;
  logic [FP_W-1:0]   add_result;

  // Response side
  logic [N-1:0]      rsp_valid;
  logic [FP_W-1:0]   rsp_data;
  logic              tag_err;

  // Clients and the adder model drive this side
  modport master (
    output req_valid, req_a, req_b, add_result_valid, add_result,
    input  req_ready, add_valid, add_a, add_b, rsp_valid, rsp_data, tag_err
  );

  // The arbiter drives this side
  modport slave (
    input  req_valid, req_a, req_b, add_result_valid, add_result,
    output req_ready, add_valid, add_a, add_b, rsp_valid, rsp_data, tag_err
  );

endinterface
`default_nettype wire

// File: rtl/fp_add_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant. Scans the request vector
//                starting at the priority pointer and returns the first hit
//                as a one-hot grant plus its encoded index.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  // First requester at or after the pointer, wrapping modulo N
  always_comb begin
    int   pos;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr_i) + k) % N;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IDW'(pos);
      end
    end
    any_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_arbiter
//  Description : Shares one pipelined FP adder among N requesters. Grants one
//                operand pair per cycle round-robin, shadows the adder with a
//                tag pipeline carrying the requester id, and routes each sum
//                back as a one-cycle one-hot response pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_add_arbiter
  import fp_pkg::*;
#(
  parameter int N   = 4,
  parameter int LAT = 3,
  parameter int IDW = $clog2(N)
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  fp_add_arbiter_if.slave  bus
);

  // Arbitration
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic [N-1:0]    w_gnt;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic            w_xfer;
  logic [FP_W-1:0] w_win_a;
  logic [FP_W-1:0] w_win_b;

  // Issue stage
  logic            add_valid_q;
  logic [FP_W-1:0] add_a_q;
  logic [FP_W-1:0] add_b_q;
  logic [IDW-1:0]  add_id_q;

  // Tag pipeline, stage LAT-1 is aligned with add_result_valid
  tag_t [LAT-1:0]  tag_q;
  tag_t            w_tag_last;
  logic [N-1:0]    w_rsp_onehot;

  // Response stage
  logic [N-1:0]    rsp_valid_q;
  logic [FP_W-1:0] rsp_data_q;
  logic            tag_err_q;

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_arbiter (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (w_gnt),
    .idx_o (w_idx),
    .any_o (w_any)
  );

  // Ready is held low during reset so no transfer can be observed
  assign bus.req_ready = rst_n ? w_gnt : '0;
  assign w_xfer        = rst_n & w_any;

  assign w_win_a = bus.req_a[int'(w_idx)*FP_W +: FP_W];
  assign w_win_b = bus.req_b[int'(w_idx)*FP_W +: FP_W];

  // Pointer moves past the winner, wrapping from N-1 to 0; holds when idle
  always_comb begin
    ptr_d = ptr_q;
    if (w_xfer) begin
      if (w_idx == IDW'(N-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = w_idx + 1'b1;
      end
    end
  end

  // Pointer and issue registers; operands hold between transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      add_valid_q <= w_xfer;
      if (w_xfer) begin
        add_a_q  <= w_win_a;
        add_b_q  <= w_win_b;
        add_id_q <= w_idx;
      end
    end
  end

  // Tag shift register: captures the issue stage, then shifts every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q[0].v  <= add_valid_q;
      tag_q[0].id <= TAG_IDW'(add_id_q);
      for (int k = 1; k < LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign w_tag_last   = tag_q[LAT-1];
  assign w_rsp_onehot = {{(N-1){1'b0}}, 1'b1} << w_tag_last.id;

  // Response and sticky error; the pulse follows the adder strobe even when
  // the tag disagrees, so an orphan result is still delivered to the tag id
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      tag_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= bus.add_result_valid ? w_rsp_onehot : '0;
      if (bus.add_result_valid) begin
        rsp_data_q <= bus.add_result;
      end
      if (w_tag_last.v != bus.add_result_valid) begin
        tag_err_q <= 1'b1;
      end
    end
  end

  assign bus.add_valid = add_valid_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.tag_err   = tag_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_add_arbiter
//  Description : Scoreboard bench for fp_add_arbiter with a model adder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_add_arbiter;
  import fp_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_add_arbiter_if #(.N(N)) bus ();

  fp_add_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0] oh;
    logic [31:0]  data;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model adder: fixed LAT-cycle pipeline with hand-computed sums
  logic        pv [LAT];
  logic [31:0] pd [LAT];
  logic        inject   = 1'b0;
  logic        suppress = 1'b0;
  logic [31:0] inj_data = 32'h0;

  function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_3F800000: return 32'h40000000;
      64'h40000000_40000000: return 32'h40800000;
      64'h3F800000_40000000: return 32'h40400000;
      64'h40400000_3F800000: return 32'h40800000;
      64'h7FC00000_3F800000: return 32'h7FC00000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        pv[k] <= 1'b0;
        pd[k] <= 32'h0;
      end
    end else begin
      pv[0] <= bus.add_valid;
      pd[0] <= model_sum(bus.add_a, bus.add_b);
      for (int k = 1; k < LAT; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
    end
  end

  assign bus.add_result_valid = (pv[LAT-1] & ~suppress) | inject;
  assign bus.add_result       = inject ? inj_data : pd[LAT-1];

  // Per-requester stimulus: one vector each, repeated rep[i] times
  logic [31:0] va [N];
  logic [31:0] vb [N];
  logic [31:0] vs [N];
  int          rep [N];
  logic        no_rsp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]       = (rep[i] > 0);
      bus.req_a[32*i +: 32]  = va[i];
      bus.req_b[32*i +: 32]  = vb[i];
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] s, input int r);
    va[i] = a; vb[i] = b; vs[i] = s; rep[i] = r;
  endtask

  // One clock: observe grant at negedge, check the issue stage after the edge
  task automatic step();
    int           g;
    logic [N-1:0] oh;
    g = -1;
    @(negedge clk);
    n_tests++;
    if (!$onehot0(bus.req_ready) || ((bus.req_ready & ~bus.req_valid) != '0) ||
        ((bus.req_valid != '0) != (bus.req_ready != '0))) begin
      n_fail++;
      $display("FAIL ready_shape: got ready=%b, valid=%b", bus.req_ready, bus.req_valid);
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i] && bus.req_valid[i]) g = i;
    end
    if (g >= 0) begin
      grants.push_back(g);
      oh    = '0;
      oh[g] = 1'b1;
      if (!no_rsp) sb.push_back('{oh: oh, data: vs[g], cyc: cyc + LAT + 2});
      rep[g]--;
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      chk("add_valid_hi", 32'(bus.add_valid), 32'd1);
      chk("add_a", bus.add_a, va[g]);
      chk("add_b", bus.add_b, vb[g]);
    end else begin
      chk("add_valid_lo", 32'(bus.add_valid), 32'd0);
    end
    apply();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < N; i++) rep[i] = 0;
    apply();
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check_reset_outputs(input string tagname);
    bus.req_valid = '1;
    #1;
    chk({tagname, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tagname, "_add_valid"}, 32'(bus.add_valid), 32'd0);
    chk({tagname, "_add_a"},     bus.add_a, 32'd0);
    chk({tagname, "_add_b"},     bus.add_b, 32'd0);
    chk({tagname, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tagname, "_rsp_data"},  bus.rsp_data, 32'd0);
    chk({tagname, "_tag_err"},   32'(bus.tag_err), 32'd0);
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) rep[i] = 0;
    apply();
    sb.delete();
    grants.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per response pulse
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid != '0) begin
        exp_t e;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b data=%h, expected no pulse",
                   bus.rsp_valid, bus.rsp_data);
        end else begin
          e = sb.pop_front();
          chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.oh));
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  int exp4 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp3 [3] = '{3, 1, 3};

  initial begin
    rst_n         = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < N; i++) set_req(i, 32'h0, 32'h0, 32'h0, 0);
    fork
      monitor();
    join_none

    // Reset values, including ready held low with requests pending
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request from requester 2: 1.0 + 2.0 = 3.0
    grants.delete();
    set_req(2, 32'h3F800000, 32'h40000000, 32'h40400000, 1);
    apply();
    step();
    chk("single_grant", (grants.size() == 1) ? grants[0] : -1, 32'd2);
    idle(LAT + 3);

    // All four requesters from reset: strict rotation
    do_reset();
    set_req(0, 32'h3F800000, 32'h3F800000, 32'h40000000, 2);
    set_req(1, 32'h40000000, 32'h40000000, 32'h40800000, 2);
    set_req(2, 32'h3F800000, 32'h40000000, 32'h40400000, 2);
    set_req(3, 32'h40400000, 32'h3F800000, 32'h40800000, 2);
    apply();
    for (int k = 0; k < 8; k++) step();
    for (int k = 0; k < 8; k++)
      chk($sformatf("rotate_grant%0d", k), (grants.size() > k) ? grants[k] : -1, exp4[k]);
    idle(LAT + 3);

    // Move ptr to 2, then requesters 1 and 3 contend: 3, 1, 3
    grants.delete();
    set_req(1, 32'h40000000, 32'h40000000, 32'h40800000, 1);
    apply();
    step();
    grants.delete();
    set_req(1, 32'h40000000, 32'h40000000, 32'h40800000, 1);
    set_req(3, 32'h40400000, 32'h3F800000, 32'h40800000, 2);
    apply();
    for (int k = 0; k < 3; k++) step();
    for (int k = 0; k < 3; k++)
      chk($sformatf("wrap_grant%0d", k), (grants.size() > k) ? grants[k] : -1, exp3[k]);
    // ptr wrapped to 0: requester 0 beats requester 1
    grants.delete();
    set_req(0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1);
    set_req(1, 32'h40000000, 32'h40000000, 32'h40800000, 1);
    apply();
    step();
    step();
    chk("after_wrap0", (grants.size() > 0) ? grants[0] : -1, 32'd0);
    chk("after_wrap1", (grants.size() > 1) ? grants[1] : -1, 32'd1);
    idle(LAT + 3);

    // NaN operand passes straight through to the issuing requester
    set_req(1, FP_QNAN, 32'h3F800000, 32'h7FC00000, 1);
    apply();
    step();
    idle(LAT + 3);
    chk("nan_tag_err", 32'(bus.tag_err), 32'd0);

    // Reset with two pairs in flight, then an orphan adder strobe
    set_req(0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1);
    set_req(1, 32'h40000000, 32'h40000000, 32'h40800000, 1);
    apply();
    step();
    step();
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) rep[i] = 0;
    apply();
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(LAT + 2);
    inj_data = 32'h40A00000;
    inject   = 1'b1;
    sb.push_back('{oh: 4'b0001, data: 32'h40A00000, cyc: cyc + 1});
    @(posedge clk);
    #1 inject = 1'b0;
    chk("orphan_tag_err", 32'(bus.tag_err), 32'd1);
    idle(3);
    chk("orphan_tag_err_sticky", 32'(bus.tag_err), 32'd1);

    // Missing adder strobe while the last tag is valid
    do_reset();
    #1;
    chk("spur_tag_err_clear", 32'(bus.tag_err), 32'd0);
    suppress = 1'b1;
    no_rsp   = 1'b1;
    set_req(3, 32'h3F800000, 32'h3F800000, 32'h40000000, 1);
    apply();
    step();
    idle(LAT + 3);
    chk("spur_tag_err", 32'(bus.tag_err), 32'd1);
    suppress = 1'b0;
    no_rsp   = 1'b0;

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound in case anything stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
